// File: rtl/dwt_pe_sched_if.sv
// Sample stream, PE operand/result bus and tagged result stream of the DWT
// PE scheduler. The scheduler takes the slave side.
interface dwt_pe_sched_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [6*DATA_WIDTH-1:0] pe_coef;
    logic [6*DATA_WIDTH-1:0] pe_data;
    logic [DATA_WIDTH-1:0]   pe_result;
    logic                    out_valid;
    logic                    out_hi;
    logic [DATA_WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_data, pe_result,
        input  in_ready, pe_coef, pe_data, out_valid, out_hi, out_data
    );

    modport slave (
        input  in_valid, in_data, pe_result,
        output in_ready, pe_coef, pe_data, out_valid, out_hi, out_data
    );
endinterface

// File: rtl/dwt_pe_sched.sv
// Sequencer for the shared 6-tap DWT PE: slides a stride-2 window over the
// sample stream, issues each window low-pass then high-pass, tags results by band.
module dwt_pe_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int PE_LATENCY = 4,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      length,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  cfg_we,
    input  logic                  cfg_hi,
    input  logic [2:0]            cfg_idx,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    dwt_pe_sched_if.slave         bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_ISSUE_LO, S_ISSUE_HI, S_SHIFT, S_DRAIN, S_DONE, S_ERR
    } state_e;

    typedef logic [5:0][DATA_WIDTH-1:0] bank_t;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [LEN_W-1:0]      win_cnt_q, win_cnt_d;
    logic                  err_q, err_d;
    bank_t                 win_q, win_d;
    bank_t                 lo_q, lo_d;
    bank_t                 hi_q, hi_d;
    bank_t                 coef_q, coef_d;
    bank_t                 data_q, data_d;
    logic [PE_LATENCY-1:0] tag_v_q, tag_v_d;
    logic [PE_LATENCY-1:0] tag_h_q, tag_h_d;

    logic in_ready;
    logic accept;
    logic pending;
    logic len_ok;
    logic push_v;
    logic push_h;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_cnt_d = win_cnt_q;
        err_d     = err_q;
        win_d     = win_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        coef_d    = coef_q;
        data_d    = data_q;
        push_v    = 1'b0;
        push_h    = 1'b0;
        done      = 1'b0;

        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        in_ready = (state_q == S_FILL) || (state_q == S_SHIFT);
        accept   = bus.in_valid && in_ready;
        len_ok   = !length[0] && (length >= LEN_W'(6));

        // Tags still travelling below the output stage; the output stage itself
        // is being consumed this cycle, so done can follow it immediately.
        pending = 1'b0;
        for (int i = 0; i < PE_LATENCY - 1; i++) begin
            pending = pending | tag_v_q[i];
        end

        if (cfg_we && !busy && (cfg_idx < 3'd6)) begin
            if (cfg_hi) hi_d[cfg_idx] = cfg_data;
            else        lo_d[cfg_idx] = cfg_data;
        end

        if (accept) begin
            win_d = {bus.in_data, win_q[5:1]};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = '0;
                    err_d     = !len_ok;
                    win_cnt_d = (length >> 1) - LEN_W'(2);
                    state_d   = len_ok ? S_FILL : S_ERR;
                end
            end
            S_FILL: begin
                if (accept) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) state_d = S_ISSUE_LO;
                end
            end
            S_ISSUE_LO: begin
                coef_d  = lo_q;
                data_d  = win_q;
                push_v  = 1'b1;
                state_d = S_ISSUE_HI;
            end
            S_ISSUE_HI: begin
                coef_d    = hi_q;
                data_d    = win_q;
                push_v    = 1'b1;
                push_h    = 1'b1;
                win_cnt_d = win_cnt_q - LEN_W'(1);
                cnt_d     = '0;
                state_d   = (win_cnt_q != LEN_W'(1)) ? S_SHIFT : S_DRAIN;
            end
            S_SHIFT: begin
                if (accept) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd1) state_d = S_ISSUE_LO;
                end
            end
            S_DRAIN: begin
                if (!pending) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        tag_v_d[0] = push_v;
        tag_h_d[0] = push_h;
        for (int i = 1; i < PE_LATENCY; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_h_d[i] = tag_h_q[i-1];
        end

        err = done && err_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            win_cnt_q <= '0;
            err_q     <= 1'b0;
            win_q     <= '0;
            // NOTE: the banks are ordinary flops rather than a RAM, so they take the reset and read back as zero.
            lo_q      <= '0;
            hi_q      <= '0;
            coef_q    <= '0;
            data_q    <= '0;
            tag_v_q   <= '0;
            tag_h_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_cnt_q <= win_cnt_d;
            err_q     <= err_d;
            win_q     <= win_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            coef_q    <= coef_d;
            data_q    <= data_d;
            tag_v_q   <= tag_v_d;
            tag_h_q   <= tag_h_d;
        end
    end

    // Operands are live in the issue cycle and held from the registers otherwise.
    assign bus.in_ready  = in_ready;
    assign bus.pe_coef   = coef_d;
    assign bus.pe_data   = data_d;
    assign bus.out_valid = tag_v_q[PE_LATENCY-1];
    assign bus.out_hi    = tag_h_q[PE_LATENCY-1];
    assign bus.out_data  = bus.pe_result;

endmodule
